// File: rtl/ds2_dual_poller.sv
// Purpose : polls two DualShock-style pads on a shared serial bus and publishes SNES-ordered buttons.
// Latency : one frame every PERIOD cycles; a pad's results appear the cycle its select is released.
// Backpres: none - poll ticks that arrive while a frame is in flight are dropped, not queued.
//
// Ports
//   clk, resetn              : single clock domain, asynchronous active-low reset
//   ds_clk, ds_mosi, ds_miso : shared serial clock (idle high) and data, LSB first
//   ds_cs[1:0]               : per-pad select, active low
//   pad0/1_buttons           : R L X A RIGHT LEFT DOWN UP START SELECT Y B, 1 = pressed
//   pad_valid[1:0]           : one-cycle pulse when that pad's outputs update
//   pad_present[1:0]         : pad answered with a recognised id and ack on its last poll
module ds2_dual_poller #(
    parameter int FREQ    = 21_600_000,
    parameter int SCLK_HZ = 250_000,
    parameter int POLL_HZ = 60
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ds_clk,
    output logic        ds_mosi,
    input  logic        ds_miso,
    output logic [1:0]  ds_cs,
    output logic [11:0] pad0_buttons,
    output logic [11:0] pad1_buttons,
    output logic [1:0]  pad_valid,
    output logic [1:0]  pad_present
);

    localparam int HALF   = FREQ / (2 * SCLK_HZ);
    localparam int PERIOD = FREQ / POLL_HZ;
    // select + 5 * (8 bits of 2*HALF + gap of 2*HALF) + deselect, twice, plus the inter-pad gap
    localparam int FRAME  = 2 * (HALF + 5 * 18 * HALF + HALF) + 4 * HALF;
    localparam int TW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CW     = $clog2(4 * HALF + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(PERIOD - 1);
    localparam logic [CW-1:0] HOLD_1     = CW'(HALF - 1);
    localparam logic [CW-1:0] HOLD_2     = CW'(2 * HALF - 1);
    localparam logic [CW-1:0] HOLD_4     = CW'(4 * HALF - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SELECT   = 3'd1;
    localparam logic [2:0] BIT_LOW  = 3'd2;
    localparam logic [2:0] BIT_HIGH = 3'd3;
    localparam logic [2:0] BYTE_GAP = 3'd4;
    localparam logic [2:0] DESELECT = 3'd5;
    localparam logic [2:0] INTERPAD = 3'd6;

    logic [TW-1:0] timer;
    logic          tick;
    logic [2:0]    state,    state_nxt;
    logic [CW-1:0] cnt,      cnt_nxt;
    logic [2:0]    bit_idx,  bit_nxt;
    logic [2:0]    byte_idx, byte_nxt;
    logic          pad,      pad_nxt;
    logic [7:0]    cmd_nxt;
    logic [7:0]    rx_shift;
    logic [7:0]    id_q, ack_q, rx0_q, rx1_q;
    logic          pad_done;
    logic          present;
    logic [11:0]   buttons;

    assign tick = (timer == TIMER_LAST);

    // Poll command: 0x01 start, 0x42 read, then three idle bytes.
    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        case (idx)
            3'd0:    cmd_byte = 8'h01;
            3'd1:    cmd_byte = 8'h42;
            default: cmd_byte = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 1'b1;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        pad_nxt   = pad;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (tick) begin
                    state_nxt = SELECT;
                    pad_nxt   = 1'b0;
                end
            end
            SELECT: if (cnt == HOLD_1) begin
                state_nxt = BIT_LOW;
                cnt_nxt   = '0;
                bit_nxt   = '0;
                byte_nxt  = '0;
            end
            BIT_LOW: if (cnt == HOLD_1) begin
                state_nxt = BIT_HIGH;
                cnt_nxt   = '0;
            end
            BIT_HIGH: if (cnt == HOLD_1) begin
                cnt_nxt = '0;
                if (bit_idx == 3'd7) begin
                    state_nxt = BYTE_GAP;
                end else begin
                    state_nxt = BIT_LOW;
                    bit_nxt   = bit_idx + 3'd1;
                end
            end
            BYTE_GAP: if (cnt == HOLD_2) begin
                cnt_nxt = '0;
                if (byte_idx == 3'd4) begin
                    state_nxt = DESELECT;
                end else begin
                    state_nxt = BIT_LOW;
                    bit_nxt   = '0;
                    byte_nxt  = byte_idx + 3'd1;
                end
            end
            DESELECT: if (cnt == HOLD_1) begin
                cnt_nxt   = '0;
                state_nxt = pad ? IDLE : INTERPAD;
            end
            INTERPAD: if (cnt == HOLD_4) begin
                cnt_nxt   = '0;
                state_nxt = SELECT;
                pad_nxt   = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign cmd_nxt  = cmd_byte(byte_nxt);
    assign pad_done = (state == DESELECT) && (cnt == HOLD_1);

    // Accept the two known pad ids (digital / analog mode) only with the 0x5A ack.
    assign present = ((id_q == 8'h41) || (id_q == 8'h73)) && (ack_q == 8'h5A);

    // Pad reports active-low; R/L merge the shoulder pairs (R1|R2, L1|L2).
    always_comb begin
        buttons = '0;
        if (present) begin
            buttons = {~rx1_q[3] | ~rx1_q[1], ~rx1_q[2] | ~rx1_q[0],
                       ~rx1_q[4], ~rx1_q[5], ~rx0_q[5], ~rx0_q[7],
                       ~rx0_q[6], ~rx0_q[4], ~rx0_q[3], ~rx0_q[0],
                       ~rx1_q[7], ~rx1_q[6]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer        <= '0;
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            byte_idx     <= '0;
            pad          <= 1'b0;
            ds_cs        <= 2'b11;
            ds_clk       <= 1'b1;
            ds_mosi      <= 1'b1;
            rx_shift     <= '0;
            id_q         <= '0;
            ack_q        <= '0;
            rx0_q        <= '0;
            rx1_q        <= '0;
            pad0_buttons <= '0;
            pad1_buttons <= '0;
            pad_valid    <= '0;
            pad_present  <= '0;
        end else begin
            timer    <= tick ? '0 : timer + 1'b1;
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            pad      <= pad_nxt;

            // Pins are registered from the next state so they change cleanly on one edge.
            if ((state_nxt == IDLE) || (state_nxt == INTERPAD))
                ds_cs <= 2'b11;
            else
                ds_cs <= pad_nxt ? 2'b01 : 2'b10;
            ds_clk  <= (state_nxt != BIT_LOW);
            ds_mosi <= ((state_nxt == BIT_LOW) || (state_nxt == BIT_HIGH)) ? cmd_nxt[bit_nxt] : 1'b1;

            // The first BIT_HIGH cycle is the cycle after ds_clk rose.
            if ((state == BIT_HIGH) && (cnt == '0))
                rx_shift <= {ds_miso, rx_shift[7:1]};

            // Capture at the start of the gap so the shift register holds all eight bits.
            if ((state == BYTE_GAP) && (cnt == '0)) begin
                case (byte_idx)
                    3'd1:    id_q  <= rx_shift;
                    3'd2:    ack_q <= rx_shift;
                    3'd3:    rx0_q <= rx_shift;
                    3'd4:    rx1_q <= rx_shift;
                    default: ;
                endcase
            end

            pad_valid <= '0;
            if (pad_done) begin
                pad_valid[pad]   <= 1'b1;
                pad_present[pad] <= present;
                if (pad)
                    pad1_buttons <= buttons;
                else
                    pad0_buttons <= buttons;
            end
        end
    end

    a_frame_fits: assert property (@(posedge clk) (HALF >= 1) && (PERIOD > FRAME));
    a_one_select: assert property (@(posedge clk) disable iff (!resetn) ds_cs != 2'b00);

endmodule

// File: tb/tb_ds2_dual_poller.sv
// Purpose : randomized bench for ds2_dual_poller with two behavioural pads and a bus monitor.
// Latency : frame every 1000 cycles (FREQ=1000, SCLK_HZ=100, POLL_HZ=1 -> HALF=5).
// Backpres: none; every wait on the DUT is bounded.
module tb_ds2_dual_poller;

    logic        clk;
    logic        resetn;
    logic        ds_clk;
    logic        ds_mosi;
    logic        ds_miso;
    logic [1:0]  ds_cs;
    logic [11:0] pad0_buttons;
    logic [11:0] pad1_buttons;
    logic [1:0]  pad_valid;
    logic [1:0]  pad_present;

    ds2_dual_poller #(.FREQ(1000), .SCLK_HZ(100), .POLL_HZ(1)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ds_clk       (ds_clk),
        .ds_mosi      (ds_mosi),
        .ds_miso      (ds_miso),
        .ds_cs        (ds_cs),
        .pad0_buttons (pad0_buttons),
        .pad1_buttons (pad1_buttons),
        .pad_valid    (pad_valid),
        .pad_present  (pad_present)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Pad responses for the next frame (main thread) and the copy latched at select (monitor).
    logic [7:0] resp[2][5];
    logic       here[2];
    logic [7:0] snap[2][5];
    logic       snap_here[2];
    logic [7:0] mosi_p[2][5];
    int         rises_p[2];
    int         nvalid[2];
    logic       cs_both_low = 1'b0;
    logic       clk_idle_toggle = 1'b0;
    int         frames_done = 0;

    task automatic set_pad(input int p, input logic h, input logic [7:0] id, input logic [7:0] ack,
                           input logic [7:0] rx0, input logic [7:0] rx1);
        here[p]    = h;
        resp[p][0] = 8'hFF;
        resp[p][1] = id;
        resp[p][2] = ack;
        resp[p][3] = rx0;
        resp[p][4] = rx1;
    endtask

    function automatic logic resp_bit(input int p, input int idx);
        logic [7:0] b;
        if (!snap_here[p] || idx >= 40) return 1'b1;
        b = snap[p][idx / 8];
        return b[idx % 8];
    endfunction

    function automatic logic model_present(input logic [7:0] id, input logic [7:0] ack);
        return (id == 8'h41 || id == 8'h73) && ack == 8'h5A;
    endfunction

    // SNES order from the pad's active-low bytes.
    function automatic logic [11:0] model_buttons(input logic [7:0] rx0, input logic [7:0] rx1);
        logic [11:0] b;
        b[11] = !rx1[3] || !rx1[1]; // R  (R1, R2)
        b[10] = !rx1[2] || !rx1[0]; // L  (L1, L2)
        b[9]  = !rx1[4];            // X  (triangle)
        b[8]  = !rx1[5];            // A  (circle)
        b[7]  = !rx0[5];            // RIGHT
        b[6]  = !rx0[7];            // LEFT
        b[5]  = !rx0[6];            // DOWN
        b[4]  = !rx0[4];            // UP
        b[3]  = !rx0[3];            // START
        b[2]  = !rx0[0];            // SELECT
        b[1]  = !rx1[7];            // Y  (square)
        b[0]  = !rx1[6];            // B  (cross)
        return b;
    endfunction

    // Bus monitor and behavioural pads, sampled on the falling clk edge.
    initial begin
        logic       prev_clk;
        logic [1:0] prev_cs;
        logic [7:0] e[5];
        logic       ep;
        logic [11:0] eb;
        prev_clk  = 1'b1;
        prev_cs   = 2'b11;
        ds_miso   = 1'b1;
        nvalid[0] = 0;
        nvalid[1] = 0;
        forever begin
            @(negedge clk);
            if (ds_cs == 2'b00) cs_both_low = 1'b1;
            if (ds_cs == 2'b11 && prev_cs == 2'b11 && ds_clk != prev_clk) clk_idle_toggle = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (!ds_cs[p]) begin
                    if (prev_cs[p]) begin
                        rises_p[p]   = 0;
                        snap_here[p] = here[p];
                        for (int b = 0; b < 5; b++) begin
                            snap[p][b]   = resp[p][b];
                            mosi_p[p][b] = 8'hAA;
                        end
                        ds_miso = resp_bit(p, 0);
                    end else if (ds_clk && !prev_clk) begin
                        if (rises_p[p] < 40) mosi_p[p][rises_p[p] / 8][rises_p[p] % 8] = ds_mosi;
                        rises_p[p]++;
                    end else if (!ds_clk && prev_clk) begin
                        ds_miso = resp_bit(p, rises_p[p]);
                    end
                end
            end
            if (ds_cs == 2'b11) ds_miso = 1'b1;
            for (int p = 0; p < 2; p++) begin
                if (pad_valid[p]) begin
                    nvalid[p]++;
                    for (int b = 0; b < 5; b++) e[b] = snap_here[p] ? snap[p][b] : 8'hFF;
                    ep = model_present(e[1], e[2]);
                    eb = ep ? model_buttons(e[3], e[4]) : 12'h000;
                    chk($sformatf("present%0d", p), pad_present[p], ep);
                    chk($sformatf("buttons%0d", p), (p == 0) ? pad0_buttons : pad1_buttons, eb);
                    chk($sformatf("rises%0d", p), rises_p[p], 40);
                    chk($sformatf("cmd%0d", p), {mosi_p[p][0], mosi_p[p][1], mosi_p[p][2],
                                                 mosi_p[p][3], mosi_p[p][4]}, 40'h0142000000);
                end
            end
            prev_clk = ds_clk;
            prev_cs  = ds_cs;
        end
    end

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!pad_valid[1] && n < 2500);
        if (!pad_valid[1]) chk("frame_timeout", 0, 1);
        else frames_done++;
    endtask

    task automatic wait_rises(input int p, input int target);
        int n = 0;
        while (!(ds_cs[p] == 1'b0 && rises_p[p] == target) && n < 2500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2500) chk("rise_timeout", 0, 1);
    endtask

    task automatic set_fixed(input logic pad1_here);
        set_pad(0, 1'b1, 8'h41, 8'h5A, 8'hEF, 8'hBF);
        set_pad(1, pad1_here, 8'h73, 8'h5A, 8'hFF, 8'hF5);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cs"},    ds_cs, 2'b11);
        chk({tag, "_clk"},   ds_clk, 1'b1);
        chk({tag, "_mosi"},  ds_mosi, 1'b1);
        chk({tag, "_b0"},    pad0_buttons, 12'h000);
        chk({tag, "_b1"},    pad1_buttons, 12'h000);
        chk({tag, "_valid"}, pad_valid, 2'b00);
        chk({tag, "_pres"},  pad_present, 2'b00);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        set_fixed(1'b1);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        #2 resetn = 1'b1;

        // Known pads: UP+B on pad 0, shoulder R on pad 1.
        wait_frame();
        @(negedge clk);
        chk("fix_b0", pad0_buttons, 12'h011);
        chk("fix_b1", pad1_buttons, 12'h800);
        chk("fix_pres", pad_present, 2'b11);

        // No pad 1: line held high.
        set_fixed(1'b0);
        wait_frame();
        @(negedge clk);
        chk("nopad_b1", pad1_buttons, 12'h000);
        chk("nopad_pres", pad_present, 2'b01);
        chk("hold_b0", pad0_buttons, 12'h011);

        for (int f = 0; f < 6; f++) begin
            for (int p = 0; p < 2; p++) begin
                logic [7:0] id;
                logic [7:0] ack;
                case ($urandom_range(0, 2))
                    0:       id = 8'h41;
                    1:       id = 8'h73;
                    default: id = 8'($urandom);
                endcase
                ack = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h5A;
                set_pad(p, $urandom_range(0, 3) != 0, id, ack, 8'($urandom), 8'($urandom));
            end
            wait_frame();
        end

        // A tick forced mid-frame must not restart or double the frame.
        set_fixed(1'b1);
        wait_rises(0, 10);
        @(posedge clk);
        #1 force dut.tick = 1'b1;
        @(posedge clk);
        #1 release dut.tick;
        wait_frame();

        // Reset during pad 0 byte 2 aborts at once.
        set_fixed(1'b1);
        wait_rises(0, 18);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        n = 0;
        while (ds_cs == 2'b11 && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
        chk("restart_delay", n, 1000);
        chk("restart_pad0", ds_cs, 2'b10);
        wait_frame();
        @(negedge clk);
        chk("recover_b0", pad0_buttons, 12'h011);
        chk("recover_b1", pad1_buttons, 12'h800);

        chk("cs_never_both", cs_both_low, 1'b0);
        chk("clk_idle_quiet", clk_idle_toggle, 1'b0);
        chk("valid_cnt0", nvalid[0], frames_done);
        chk("valid_cnt1", nvalid[1], frames_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
